// File: rtl/sata_cmd_arbiter.sv
// Two-requester arbiter in front of a single SATA DMA command/write/read port set.
// It accepts one command at a time, forwards it downstream, routes the data streams to the owner, and reports done/fault back to it.
module sata_cmd_arbiter #(
   parameter string ARB_MODE = "ROUND_ROBIN"
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        linkup,

   input  logic        s0_cmd_valid,
   input  logic        s0_cmd_type,
   input  logic [47:0] s0_cmd_address,
   input  logic [47:0] s0_cmd_size,
   output logic        s0_cmd_ready,
   output logic        s0_cmd_done,
   output logic        s0_cmd_fault,
   input  logic [31:0] s0_wr_dat,
   input  logic        s0_wr_val,
   output logic        s0_wr_rdy,
   output logic [31:0] s0_rd_dat,
   output logic        s0_rd_val,
   input  logic        s0_rd_rdy,

   input  logic        s1_cmd_valid,
   input  logic        s1_cmd_type,
   input  logic [47:0] s1_cmd_address,
   input  logic [47:0] s1_cmd_size,
   output logic        s1_cmd_ready,
   output logic        s1_cmd_done,
   output logic        s1_cmd_fault,
   input  logic [31:0] s1_wr_dat,
   input  logic        s1_wr_val,
   output logic        s1_wr_rdy,
   output logic [31:0] s1_rd_dat,
   output logic        s1_rd_val,
   input  logic        s1_rd_rdy,

   output logic        m_cmd_valid,
   output logic        m_cmd_type,
   output logic [47:0] m_cmd_address,
   output logic [47:0] m_cmd_size,
   input  logic        m_cmd_ready,
   input  logic        m_cmd_fault,
   output logic [31:0] m_wr_dat,
   output logic        m_wr_val,
   input  logic        m_wr_rdy,
   input  logic [31:0] m_rd_dat,
   input  logic        m_rd_val,
   output logic        m_rd_rdy,

   output logic [1:0]  stat_grant,
   output logic        stat_busy
);

   localparam bit FIXED_PRIO = (ARB_MODE == "FIXED");

   typedef enum logic [1:0] {IDLE, ISSUE, ACTIVE, DONE} state_t;

   state_t      state_q, state_d;
   logic        owner_q, owner_d;
   logic        last_grant_q, last_grant_d;
   logic        first_q, first_d;
   logic        m_cmd_valid_q, m_cmd_valid_d;
   logic        m_cmd_type_q, m_cmd_type_d;
   logic [47:0] m_cmd_address_q, m_cmd_address_d;
   logic [47:0] m_cmd_size_q, m_cmd_size_d;
   logic [1:0]  done_q, done_d;
   logic [1:0]  fault_q, fault_d;

   logic        winner;
   logic        accept;
   logic        stream_on;
   logic [1:0]  owner_onehot;
   logic        sel_type;
   logic [47:0] sel_address;
   logic [47:0] sel_size;

   // Ties go to the port that did not win last time, unless fixed priority is selected.
   always_comb begin
      winner = 1'b0;
      if (s0_cmd_valid && s1_cmd_valid)
         winner = FIXED_PRIO ? 1'b0 : ~last_grant_q;
      else
         winner = s1_cmd_valid;
   end

   assign accept       = (state_q == IDLE) && linkup && (s0_cmd_valid || s1_cmd_valid);
   assign s0_cmd_ready = accept && !winner;
   assign s1_cmd_ready = accept && winner;

   assign sel_type     = winner ? s1_cmd_type    : s0_cmd_type;
   assign sel_address  = winner ? s1_cmd_address : s0_cmd_address;
   assign sel_size     = winner ? s1_cmd_size    : s0_cmd_size;
   assign owner_onehot = {owner_q, ~owner_q};

   always_comb begin
      state_d         = state_q;
      owner_d         = owner_q;
      last_grant_d    = last_grant_q;
      first_d         = first_q;
      m_cmd_valid_d   = m_cmd_valid_q;
      m_cmd_type_d    = m_cmd_type_q;
      m_cmd_address_d = m_cmd_address_q;
      m_cmd_size_d    = m_cmd_size_q;
      done_d          = 2'b00;
      fault_d         = 2'b00;
      case (state_q)
         IDLE: begin
            if (accept) begin
               m_cmd_type_d    = sel_type;
               m_cmd_address_d = sel_address;
               m_cmd_size_d    = sel_size;
               owner_d         = winner;
               last_grant_d    = winner;
               if (sel_size != 48'd0) begin
                  state_d       = ISSUE;
                  m_cmd_valid_d = 1'b1;
               end else begin
                  state_d = DONE;
                  done_d  = {winner, ~winner};
                  fault_d = {winner, ~winner};
               end
            end
         end
         ISSUE: begin
            if (!linkup) begin
               state_d       = DONE;
               m_cmd_valid_d = 1'b0;
               done_d        = owner_onehot;
               fault_d       = owner_onehot;
            end else if (m_cmd_ready) begin
               state_d       = ACTIVE;
               m_cmd_valid_d = 1'b0;
               first_d       = 1'b1;
            end
         end
         ACTIVE: begin
            first_d = 1'b0;
            // Ready is still high from the issue handshake on the first cycle, so it is ignored.
            if (!linkup) begin
               state_d = DONE;
               done_d  = owner_onehot;
               fault_d = owner_onehot;
            end else if (!first_q && m_cmd_ready) begin
               state_d = DONE;
               done_d  = owner_onehot;
               fault_d = m_cmd_fault ? owner_onehot : 2'b00;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q         <= IDLE;
         owner_q         <= 1'b0;
         last_grant_q    <= 1'b1;
         first_q         <= 1'b0;
         m_cmd_valid_q   <= 1'b0;
         m_cmd_type_q    <= 1'b0;
         m_cmd_address_q <= 48'd0;
         m_cmd_size_q    <= 48'd0;
         done_q          <= 2'b00;
         fault_q         <= 2'b00;
      end else begin
         state_q         <= state_d;
         owner_q         <= owner_d;
         last_grant_q    <= last_grant_d;
         first_q         <= first_d;
         m_cmd_valid_q   <= m_cmd_valid_d;
         m_cmd_type_q    <= m_cmd_type_d;
         m_cmd_address_q <= m_cmd_address_d;
         m_cmd_size_q    <= m_cmd_size_d;
         done_q          <= done_d;
         fault_q         <= fault_d;
      end
   end

   assign m_cmd_valid   = m_cmd_valid_q;
   assign m_cmd_type    = m_cmd_type_q;
   assign m_cmd_address = m_cmd_address_q;
   assign m_cmd_size    = m_cmd_size_q;

   assign s0_cmd_done  = done_q[0];
   assign s1_cmd_done  = done_q[1];
   assign s0_cmd_fault = fault_q[0];
   assign s1_cmd_fault = fault_q[1];

   assign stat_busy  = (state_q != IDLE);
   assign stat_grant = stat_busy ? owner_onehot : 2'b00;

   // Streams are only connected while a command is outstanding downstream.
   assign stream_on = (state_q == ISSUE) || (state_q == ACTIVE);

   assign m_wr_dat  = owner_q ? s1_wr_dat : s0_wr_dat;
   assign m_wr_val  = stream_on && (owner_q ? s1_wr_val : s0_wr_val);
   assign s0_wr_rdy = stream_on && !owner_q && m_wr_rdy;
   assign s1_wr_rdy = stream_on && owner_q && m_wr_rdy;

   assign s0_rd_dat = m_rd_dat;
   assign s1_rd_dat = m_rd_dat;
   assign s0_rd_val = stream_on && !owner_q && m_rd_val;
   assign s1_rd_val = stream_on && owner_q && m_rd_val;
   assign m_rd_rdy  = stream_on && (owner_q ? s1_rd_rdy : s0_rd_rdy);

endmodule

// File: tb/tb_sata_cmd_arbiter.sv
// Randomized bench: one round-robin and one fixed-priority arbiter share the same stimulus,
// each checked every cycle against a command-lifetime reference model.
`timescale 1ns/1ps
module tb_sata_cmd_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        linkup;
   logic        s0_v, s1_v, s0_t, s1_t;
   logic [47:0] s0_a, s1_a, s0_s, s1_s;
   logic [31:0] s0_wd, s1_wd, m_rd_dat;
   logic        s0_wv, s1_wv, s0_rr, s1_rr;
   logic        m_cmd_ready, m_cmd_fault, m_wr_rdy, m_rd_val;

   logic        rdy0 [2], rdy1 [2], done0 [2], done1 [2], flt0 [2], flt1 [2];
   logic        wrrdy0 [2], wrrdy1 [2], rdval0 [2], rdval1 [2];
   logic [31:0] rddat0 [2], rddat1 [2], mwdat [2];
   logic        mval [2], mtype [2], mwval [2], mrrdy [2], sbusy [2];
   logic [47:0] maddr [2], msize [2];
   logic [1:0]  grant [2];

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

`define DUT_PORTS(I) \
      .clk(clk), .reset(rst), .linkup(linkup), \
      .s0_cmd_valid(s0_v), .s0_cmd_type(s0_t), .s0_cmd_address(s0_a), .s0_cmd_size(s0_s), \
      .s0_cmd_ready(rdy0[I]), .s0_cmd_done(done0[I]), .s0_cmd_fault(flt0[I]), \
      .s0_wr_dat(s0_wd), .s0_wr_val(s0_wv), .s0_wr_rdy(wrrdy0[I]), \
      .s0_rd_dat(rddat0[I]), .s0_rd_val(rdval0[I]), .s0_rd_rdy(s0_rr), \
      .s1_cmd_valid(s1_v), .s1_cmd_type(s1_t), .s1_cmd_address(s1_a), .s1_cmd_size(s1_s), \
      .s1_cmd_ready(rdy1[I]), .s1_cmd_done(done1[I]), .s1_cmd_fault(flt1[I]), \
      .s1_wr_dat(s1_wd), .s1_wr_val(s1_wv), .s1_wr_rdy(wrrdy1[I]), \
      .s1_rd_dat(rddat1[I]), .s1_rd_val(rdval1[I]), .s1_rd_rdy(s1_rr), \
      .m_cmd_valid(mval[I]), .m_cmd_type(mtype[I]), .m_cmd_address(maddr[I]), .m_cmd_size(msize[I]), \
      .m_cmd_ready(m_cmd_ready), .m_cmd_fault(m_cmd_fault), \
      .m_wr_dat(mwdat[I]), .m_wr_val(mwval[I]), .m_wr_rdy(m_wr_rdy), \
      .m_rd_dat(m_rd_dat), .m_rd_val(m_rd_val), .m_rd_rdy(mrrdy[I]), \
      .stat_grant(grant[I]), .stat_busy(sbusy[I])

   sata_cmd_arbiter #(.ARB_MODE("ROUND_ROBIN")) dut_rr (`DUT_PORTS(0));
   sata_cmd_arbiter #(.ARB_MODE("FIXED"))       dut_fx (`DUT_PORTS(1));

   // Reference model: a command is either being executed downstream (busy), or its
   // completion pulse is pending (pulse); neither means the arbiter is free.
   bit          busy [2], issued [2], waited [2], pulse [2], pfault [2], own [2], last [2];
   logic        ctype [2];
   logic [47:0] caddr [2], csize [2];
   int          grants_fx_port1 = 0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
      else
         n_pass++;
   endtask

   task automatic model_reset(input int i);
      busy[i] = 0; issued[i] = 0; waited[i] = 0; pulse[i] = 0; pfault[i] = 0;
      own[i] = 0; last[i] = 1; ctype[i] = 0; caddr[i] = '0; csize[i] = '0;
   endtask

   task automatic step();
      if (rst) begin
         model_reset(0);
         model_reset(1);
      end
      #1;
      for (int i = 0; i < 2; i++) begin
         bit          free, win, r0, r1, str, o;
         logic [16:0] e_ctl, o_ctl;
         string       sfx;
         sfx  = (i == 0) ? "rr" : "fx";
         free = !busy[i] && !pulse[i];
         o    = own[i];
         if (s0_v && s1_v) win = (i == 1) ? 1'b0 : !last[i];
         else              win = s1_v;
         r0  = !rst && free && linkup && s0_v && !win;
         r1  = !rst && free && linkup && s1_v && win;
         str = busy[i];
         e_ctl = {r0, r1, pulse[i] && !o, pulse[i] && o,
                  pulse[i] && !o && pfault[i], pulse[i] && o && pfault[i],
                  busy[i] && !issued[i], busy[i] || pulse[i],
                  (busy[i] || pulse[i]) ? {o, !o} : 2'b00,
                  str && (o ? s1_wv : s0_wv),
                  str && !o && m_wr_rdy, str && o && m_wr_rdy,
                  str && !o && m_rd_val, str && o && m_rd_val,
                  str && (o ? s1_rr : s0_rr)};
         o_ctl = {rdy0[i], rdy1[i], done0[i], done1[i], flt0[i] & done0[i], flt1[i] & done1[i],
                  mval[i], sbusy[i], grant[i], mwval[i], wrrdy0[i], wrrdy1[i],
                  rdval0[i], rdval1[i], mrrdy[i]};
         check({"ctl_", sfx}, 128'(o_ctl), 128'(e_ctl));
         check({"mcmd_", sfx}, 128'({mtype[i], maddr[i], msize[i]}), 128'({ctype[i], caddr[i], csize[i]}));
         check({"rd_dat_", sfx}, 128'({rddat0[i], rddat1[i]}), 128'({m_rd_dat, m_rd_dat}));
         if (str && (o ? s1_wv : s0_wv))
            check({"wr_dat_", sfx}, 128'(mwdat[i]), 128'(o ? s1_wd : s0_wd));
         if (!rst) begin
            if (pulse[i]) begin
               pulse[i] = 0;
            end else if (busy[i]) begin
               if (!linkup) begin
                  busy[i] = 0; pulse[i] = 1; pfault[i] = 1;
               end else if (!issued[i]) begin
                  if (m_cmd_ready) begin issued[i] = 1; waited[i] = 0; end
               end else if (!waited[i]) begin
                  waited[i] = 1;
               end else if (m_cmd_ready) begin
                  busy[i] = 0; pulse[i] = 1; pfault[i] = m_cmd_fault;
               end
            end else if (r0 || r1) begin
               own[i]   = r1;
               last[i]  = r1;
               ctype[i] = r1 ? s1_t : s0_t;
               caddr[i] = r1 ? s1_a : s0_a;
               csize[i] = r1 ? s1_s : s0_s;
               if (i == 1 && r1) grants_fx_port1++;
               if (csize[i] == 48'd0) begin pulse[i] = 1; pfault[i] = 1; end
               else begin busy[i] = 1; issued[i] = 0; end
            end
         end
      end
      @(negedge clk);
   endtask

   task automatic randomize_inputs();
      linkup      = ($urandom_range(0, 99) < 96);
      s0_v        = ($urandom_range(0, 9) < 7);
      s1_v        = ($urandom_range(0, 9) < 7);
      s0_t        = 1'($urandom_range(0, 1));
      s1_t        = 1'($urandom_range(0, 1));
      s0_a        = {16'($urandom), $urandom};
      s1_a        = {16'($urandom), $urandom};
      s0_s        = ($urandom_range(0, 3) == 0) ? 48'd0 : 48'($urandom_range(1, 4096));
      s1_s        = ($urandom_range(0, 3) == 0) ? 48'd0 : 48'($urandom_range(1, 4096));
      s0_wd       = $urandom;
      s1_wd       = $urandom;
      s0_wv       = 1'($urandom_range(0, 1));
      s1_wv       = 1'($urandom_range(0, 1));
      s0_rr       = 1'($urandom_range(0, 1));
      s1_rr       = 1'($urandom_range(0, 1));
      m_cmd_ready = ($urandom_range(0, 2) == 0);
      m_cmd_fault = 1'($urandom_range(0, 1));
      m_wr_rdy    = 1'($urandom_range(0, 1));
      m_rd_val    = 1'($urandom_range(0, 1));
      m_rd_dat    = $urandom;
   endtask

   initial begin
      rst = 1'b1;
      linkup = 1'b1;
      {s0_v, s1_v, s0_t, s1_t, s0_wv, s1_wv, s0_rr, s1_rr} = '0;
      {s0_a, s1_a, s0_s, s1_s} = '0;
      {s0_wd, s1_wd, m_rd_dat} = '0;
      {m_cmd_ready, m_cmd_fault, m_wr_rdy, m_rd_val} = '0;
      @(negedge clk);
      step();
      step();

      // Write on port 0, then reset while the command is in ISSUE.
      rst = 1'b0;
      s0_v = 1'b1; s0_t = 1'b1; s0_a = 48'h100; s0_s = 48'd8;
      step();
      s0_v = 1'b0;
      rst = 1'b1;
      step();
      step();

      // After release, port 0 must win the first simultaneous request in both modes.
      rst = 1'b0;
      s0_v = 1'b1; s1_v = 1'b1; s1_s = 48'd0; s0_s = 48'd0;
      step();

      for (int n = 0; n < 4000; n++) begin
         randomize_inputs();
         step();
      end

      // Fixed priority must still let port 1 through when it requests alone.
      check("fx_port1_granted", 128'(grants_fx_port1 > 0), 128'(1));
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
